uart_cmd_parser: RTL and testbench

- Receive-side counterpart of the response string table. Consumes command bytes from the UART receiver and assembles them into a line buffer.
- On each line terminator, classifies the line and emits a 2-bit response id, one of SHELL, ERROR or PONG. These are the same ids the string table indexes.
- Sits between the UART RX byte interface and the TX response sequencer.

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_cmd_parser_line_buffer.sv | 64 ++++++
 rtl/uart_cmd_parser.sv | 118 +++++++++++
 tb/tb_uart_cmd_parser.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path: response ids (also indexed by
// the response string table), control-character codes and parser states.
package uart_cmd_pkg;

    localparam logic [1:0] RESP_START = 2'd0;
    localparam logic [1:0] RESP_SHELL = 2'd1;
    localparam logic [1:0] RESP_ERROR = 2'd2;
    localparam logic [1:0] RESP_PONG  = 2'd3;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_MATCH,
        ST_RESPOND
    } state_e;

    // Storage always holds at least the four bytes the comparator inspects.
    function automatic int buf_depth(input int max_len);
        return (max_len < 4) ? 4 : max_len;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_line_buffer.sv
// Line buffer for the command parser: byte storage, fill length and an
// overflow flag, driven by store / backspace / clear strobes.
module line_buffer
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        store_i,
    input  logic        backspace_i,
    input  logic        clear_i,
    input  logic [7:0]  data_i,
    output logic [31:0] head_o,
    output logic [4:0]  len_o,
    output logic        overflow_o
);

    localparam int         DEPTH     = buf_depth(MAX_LEN);
    localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

    logic [DEPTH*8-1:0] data_q, data_d;
    logic [4:0]         len_q, len_d;
    logic               ovf_q, ovf_d;

    // Length saturates at MAX_LEN; bytes beyond that only raise the overflow flag.
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            len_d = '0;
            ovf_d = 1'b0;
        end else if (backspace_i) begin
            if (len_q != 5'd0) begin
                len_d = len_q - 5'd1;
            end
        end else if (store_i) begin
            if (len_q < MAX_LEN_W) begin
                data_d[{len_q, 3'b000} +: 8] = data_i;
                len_d = len_q + 5'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            len_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            ovf_q  <= ovf_d;
        end
    end

    assign head_o     = data_q[31:0];
    assign len_o      = len_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: collects received bytes into a line, classifies each
// terminated line and hands a response id to the TX sequencer.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int          MAX_LEN  = 16,
    parameter logic [31:0] CMD_PING = "PING"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       resp_ready,
    output logic       resp_valid,
    output logic [1:0] resp_id,
    output logic       rx_drop,
    output logic [4:0] line_len
);

    state_e      state_q, state_d;
    logic        last_cr_q, last_cr_d;
    logic [1:0]  resp_id_q, resp_id_d;
    logic        drop_q, drop_d;

    logic        buf_store, buf_backspace, buf_clear;
    logic [31:0] buf_head;
    logic [4:0]  buf_len;
    logic        buf_ovf;
    logic [31:0] cmd_bytes;
    logic        is_ping;

    line_buffer #(.MAX_LEN(MAX_LEN)) u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .store_i    (buf_store),
        .backspace_i(buf_backspace),
        .clear_i    (buf_clear),
        .data_i     (rx_data),
        .head_o     (buf_head),
        .len_o      (buf_len),
        .overflow_o (buf_ovf)
    );

    // Buffer byte 0 is the first character received, i.e. the string's MSB.
    assign cmd_bytes = {CMD_PING[7:0], CMD_PING[15:8], CMD_PING[23:16], CMD_PING[31:24]};
    assign is_ping   = (buf_len == 5'd4) && (buf_head == cmd_bytes);

    always_comb begin
        state_d       = state_q;
        last_cr_d     = last_cr_q;
        resp_id_d     = resp_id_q;
        drop_d        = 1'b0;
        buf_store     = 1'b0;
        buf_backspace = 1'b0;
        buf_clear     = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (rx_valid) begin
                    last_cr_d = 1'b0;
                    if (rx_data == ASCII_CR) begin
                        last_cr_d = 1'b1;
                        state_d   = ST_MATCH;
                    end else if (rx_data == ASCII_LF) begin
                        // The LF of a CRLF pair was already terminated by its CR.
                        if (!last_cr_q) begin
                            state_d = ST_MATCH;
                        end
                    end else if (rx_data == ASCII_BS || rx_data == ASCII_DEL) begin
                        buf_backspace = 1'b1;
                    end else begin
                        buf_store = 1'b1;
                    end
                end
            end
            ST_MATCH: begin
                drop_d    = rx_valid;
                buf_clear = 1'b1;
                state_d   = ST_RESPOND;
                if (buf_ovf) begin
                    resp_id_d = RESP_ERROR;
                end else if (buf_len == 5'd0) begin
                    resp_id_d = RESP_SHELL;
                end else if (is_ping) begin
                    resp_id_d = RESP_PONG;
                end else begin
                    resp_id_d = RESP_ERROR;
                end
            end
            ST_RESPOND: begin
                drop_d = rx_valid;
                if (resp_ready) begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            last_cr_q <= 1'b0;
            resp_id_q <= RESP_START;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_cr_q <= last_cr_d;
            resp_id_q <= resp_id_d;
            drop_q    <= drop_d;
        end
    end

    assign resp_valid = (state_q == ST_RESPOND);
    assign resp_id    = resp_id_q;
    assign rx_drop    = drop_q;
    assign line_len   = buf_len;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a line-level reference model predicts
// response ids, timing and drops; a monitor checks what the DUT presents.
module tb_uart_cmd_parser;

    localparam int          MAX_LEN = 16;
    localparam byte unsigned CR     = 8'h0D;
    localparam byte unsigned LF     = 8'h0A;
    localparam byte unsigned BS     = 8'h08;
    localparam byte unsigned DEL    = 8'h7F;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] rx_data    = 8'h00;
    logic       rx_valid   = 1'b0;
    logic       resp_ready = 1'b1;
    logic       resp_valid;
    logic [1:0] resp_id;
    logic       rx_drop;
    logic [4:0] line_len;

    uart_cmd_parser #(.MAX_LEN(MAX_LEN), .CMD_PING("PING")) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .resp_ready(resp_ready),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .rx_drop   (rx_drop),
        .line_len  (line_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checkCount = 0;
    int passCount  = 0;
    int readyMode  = 0;
    int pending    = 0;

    typedef struct {
        int id;
        int at;
    } exp_t;

    exp_t         expQ[$];
    int           dropQ[$];
    byte unsigned line[$];
    bit           ovf      = 1'b0;
    bit           lastCr   = 1'b0;
    bit [31:0]    pingWord = "PING";

    // resp_ready: 0 = always accept, 1 = random back-pressure, 2 = hold off
    always @(posedge clk) begin
        #2;
        if (readyMode == 0) resp_ready = 1'b1;
        else if (readyMode == 1) resp_ready = 1'($urandom_range(0, 1));
        else resp_ready = 1'b0;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Reference model: the line as a queue of characters, classified at terminators.
    task automatic modelByte(input byte unsigned b, output bit term, output int id);
        term = 1'b0;
        id   = 0;
        if (b == CR) begin
            lastCr = 1'b1;
            term   = 1'b1;
        end else if (b == LF) begin
            if (lastCr) lastCr = 1'b0;
            else term = 1'b1;
        end else begin
            lastCr = 1'b0;
            if (b == BS || b == DEL) begin
                if (line.size() > 0) void'(line.pop_back());
            end else if (line.size() < MAX_LEN) begin
                line.push_back(b);
            end else begin
                ovf = 1'b1;
            end
        end
        if (term) begin
            if (ovf) id = 2;
            else if (line.size() == 0) id = 1;
            else if (line.size() == 4 && line[0] == pingWord[31:24] && line[1] == pingWord[23:16]
                     && line[2] == pingWord[15:8] && line[3] == pingWord[7:0]) id = 3;
            else id = 2;
            line.delete();
            ovf = 1'b0;
        end
    endtask

    task automatic applyStimulus(input byte unsigned b);
        bit term;
        int id;
        int n;
        modelByte(b, term, id);
        n        = cyc;
        rx_data  = b;
        rx_valid = 1'b1;
        if (term) begin
            expQ.push_back('{id, n + 2});
            pending++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (!term) checkOutput("lineLen", int'(line_len), line.size());
    endtask

    task automatic sendDrop(input byte unsigned b);
        rx_data  = b;
        rx_valid = 1'b1;
        dropQ.push_back(cyc + 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pending <= 0 && !resp_valid) return;
        end
        checkCount++;
        $display("[TB] FAIL waitIdle: response still outstanding after 200 cycles, pending %0d", pending);
    endtask

    task automatic waitValid();
        for (int i = 0; i < 50; i++) begin
            if (resp_valid) return;
            @(negedge clk);
        end
        checkCount++;
        $display("[TB] FAIL waitValid: resp_valid got 0, expected 1 within 50 cycles");
    endtask

    task automatic applyReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("resetValid", int'(resp_valid), 0);
        checkOutput("resetId", int'(resp_id), 0);
        checkOutput("resetDrop", int'(rx_drop), 0);
        checkOutput("resetLen", int'(line_len), 0);
        line.delete();
        ovf     = 1'b0;
        lastCr  = 1'b0;
        expQ.delete();
        dropQ.delete();
        pending = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit   prevValid = 1'b0;
    bit   allReady  = 1'b0;
    bit   expDrop;
    int   validLen  = 0;
    int   heldId    = 0;
    exp_t e;

    // Monitor: checks each response against the scoreboard and every drop pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (resp_valid && !prevValid) begin
                validLen = 0;
                allReady = 1'b1;
                heldId   = resp_id;
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpectedResp: got id %0d, expected no response (cycle %0d)", resp_id, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("respId", int'(resp_id), e.id);
                    checkOutput("respLatency", cyc, e.at);
                end
            end else if (resp_valid) begin
                checkOutput("respStable", int'(resp_id), heldId);
            end else if (prevValid && allReady) begin
                checkOutput("validCycles", validLen, 1);
            end
            if (resp_valid) begin
                validLen++;
                allReady = allReady && resp_ready;
                if (resp_ready) pending--;
            end
            expDrop = (dropQ.size() > 0) && (dropQ[0] == cyc);
            if (expDrop) void'(dropQ.pop_front());
            if (rx_drop || expDrop) checkOutput("rxDrop", int'(rx_drop), int'(expDrop));
            prevValid = resp_valid;
        end
    end

    byte unsigned alpha[10] = '{8'h50, 8'h49, 8'h4E, 8'h47, 8'h41, 8'h70, 8'h78, 8'h08, 8'h7F, 8'h5A};

    initial begin
        #1;
        checkOutput("resetValid", int'(resp_valid), 0);
        checkOutput("resetId", int'(resp_id), 0);
        checkOutput("resetDrop", int'(rx_drop), 0);
        checkOutput("resetLen", int'(line_len), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sendString("PING"); applyStimulus(CR); waitIdle();
        checkOutput("lineLenCleared", int'(line_len), line.size());

        sendString("PONG"); applyStimulus(CR); waitIdle();
        applyStimulus(LF); waitIdle();
        applyStimulus(LF); waitIdle();

        sendString("PINGX"); applyStimulus(BS); applyStimulus(CR); waitIdle();
        sendString("PINGZ"); applyStimulus(DEL); applyStimulus(LF); waitIdle();
        sendString("ping"); applyStimulus(CR); waitIdle();
        applyStimulus(BS); applyStimulus(CR); waitIdle();

        repeat (20) applyStimulus(8'h41);
        applyStimulus(CR); waitIdle();
        sendString("PING"); applyStimulus(CR); waitIdle();

        readyMode = 2;
        sendString("PING"); applyStimulus(CR);
        waitValid();
        repeat (3) @(negedge clk);
        sendDrop(8'h51);
        repeat (7) @(negedge clk);
        readyMode = 0;
        waitIdle();
        sendString("PING"); applyStimulus(CR); waitIdle();

        sendString("PI");
        applyReset();
        sendString("PING"); applyStimulus(CR); waitIdle();

        readyMode = 2;
        sendString("PING"); applyStimulus(CR);
        waitValid();
        applyReset();
        readyMode = 0;
        repeat (5) @(negedge clk);
        sendString("PING"); applyStimulus(CR); waitIdle();

        readyMode = 1;
        for (int k = 0; k < 40; k++) begin
            int len;
            int t;
            if ($urandom_range(0, 2) == 0) sendString("PING");
            len = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 0) len = len % 3;
            for (int j = 0; j < len; j++) applyStimulus(alpha[$urandom_range(0, 9)]);
            t = $urandom_range(0, 2);
            if (t == 0) begin
                applyStimulus(CR); waitIdle();
            end else if (t == 1) begin
                applyStimulus(LF); waitIdle();
            end else begin
                applyStimulus(CR); waitIdle();
                applyStimulus(LF); waitIdle();
            end
        end
        readyMode = 0;
        repeat (4) @(negedge clk);
        checkOutput("leftoverResp", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
